// File: rtl/usbdev_pkg.sv
// Shared USB device types and constants used by the always-on blocks.
package usbdev_pkg;

   typedef enum logic [1:0] {
      RtxIdle,
      RtxWaitIdle,
      RtxDriveK,
      RtxRelease
   } resume_tx_state_e;

   typedef enum logic [1:0] {
      LsJ,
      LsK,
      LsSe0,
      LsSe1
   } line_state_e;

   // Full-speed idle/resume encodings as {dp,dn} with no pin flip.
   localparam logic [1:0] UsbJFs = 2'b10;
   localparam logic [1:0] UsbKFs = 2'b01;

   // A flipped pad pair presents {dn,dp}, so swap the two bits.
   function automatic logic [1:0] flip_pins(input logic [1:0] v, input logic flip);
      return flip ? {v[0], v[1]} : v;
   endfunction

endpackage

// File: rtl/usbdev_aon_line_state.sv
// Combinational J/K/SE0/SE1 decode of the synchronized bus pair, honouring pin flip.
module usbdev_aon_line_state
   import usbdev_pkg::*;
(
   input  logic        usb_dp_i,
   input  logic        usb_dn_i,
   input  logic        pinflip_i,
   output line_state_e line_state_o
);

   logic [1:0] pins;

   assign pins = {usb_dp_i, usb_dn_i};

   always_comb begin
      line_state_o = LsSe1;
      if (pins == 2'b00) begin
         line_state_o = LsSe0;
      end else if (pins == flip_pins(UsbJFs, pinflip_i)) begin
         line_state_o = LsJ;
      end else if (pins == flip_pins(UsbKFs, pinflip_i)) begin
         line_state_o = LsK;
      end
   end

endmodule

// File: rtl/usbdev_aon_resume_tx.sv
// Always-on remote-wakeup transmitter: waits for a quiet J bus while suspended,
// drives K for a fixed time, then releases the pads.
module usbdev_aon_resume_tx
   import usbdev_pkg::*;
#(
   parameter int unsigned IdleMinCycles = 1000,
   parameter int unsigned ResumeCycles  = 2000,
   parameter int unsigned CntW          = 11
) (
   input  logic clk_aon_i,
   input  logic rst_aon_i,
   input  logic usb_dp_i,
   input  logic usb_dn_i,
   input  logic pinflip_i,
   input  logic suspended_i,
   input  logic rwake_en_i,
   input  logic wake_req_i,
   output logic usb_oe_o,
   output logic usb_dp_o,
   output logic usb_dn_o,
   output logic busy_o,
   output logic done_o,
   output logic aborted_o
);

   localparam logic [CntW-1:0] IdleLast   = CntW'(IdleMinCycles - 1);
   localparam logic [CntW-1:0] ResumeLast = CntW'(ResumeCycles - 1);

   resume_tx_state_e state_q;
   logic [CntW-1:0]  cnt_q;
   logic             armed_q;
   logic             oe_q, dp_q, dn_q, busy_q, done_q, aborted_q;

   line_state_e line_state;
   logic        line_j;
   logic        abort_cond;
   logic        req_edge;
   logic [1:0]  k_val;

   usbdev_aon_line_state u_line_state (
      .usb_dp_i     (usb_dp_i),
      .usb_dn_i     (usb_dn_i),
      .pinflip_i    (pinflip_i),
      .line_state_o (line_state)
   );

   assign line_j     = (line_state == LsJ);
   assign abort_cond = !suspended_i || !rwake_en_i;
   // Level request is only honoured once it has been seen low since the last use.
   assign req_edge   = wake_req_i && armed_q;
   assign k_val      = flip_pins(UsbKFs, pinflip_i);

   always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
      if (rst_aon_i) begin
         state_q   <= RtxIdle;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         oe_q      <= 1'b0;
         dp_q      <= 1'b0;
         dn_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         // Outputs follow the state one cycle later.
         oe_q      <= (state_q == RtxDriveK);
         dp_q      <= (state_q == RtxDriveK) ? k_val[1] : 1'b0;
         dn_q      <= (state_q == RtxDriveK) ? k_val[0] : 1'b0;
         busy_q    <= (state_q != RtxIdle);
         done_q    <= (state_q == RtxRelease);
         aborted_q <= 1'b0;

         if (!wake_req_i) begin
            armed_q <= 1'b1;
         end

         case (state_q)
            RtxIdle: begin
               if (req_edge) begin
                  armed_q <= 1'b0;
                  if (abort_cond) begin
                     aborted_q <= 1'b1;
                  end else begin
                     state_q <= RtxWaitIdle;
                     cnt_q   <= '0;
                  end
               end
            end
            RtxWaitIdle: begin
               if (abort_cond) begin
                  state_q   <= RtxIdle;
                  cnt_q     <= '0;
                  aborted_q <= 1'b1;
               end else if (!line_j) begin
                  cnt_q <= '0;
               end else if (cnt_q == IdleLast) begin
                  state_q <= RtxDriveK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RtxDriveK: begin
               // Abort wins over the terminal count so done_o never follows a cancel.
               if (abort_cond) begin
                  state_q   <= RtxIdle;
                  cnt_q     <= '0;
                  aborted_q <= 1'b1;
               end else if (cnt_q == ResumeLast) begin
                  state_q <= RtxRelease;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RtxRelease: begin
               state_q <= RtxIdle;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= RtxIdle;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign usb_oe_o  = oe_q;
   assign usb_dp_o  = dp_q;
   assign usb_dn_o  = dn_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign aborted_o = aborted_q;

endmodule

// File: tb/tb_usbdev_aon_resume_tx.sv
// Directed bench for the remote-wakeup transmitter with short idle/resume timings.
module tb_usbdev_aon_resume_tx;

   logic clk = 1'b0;
   logic rst, dp_i, dn_i, pinflip, susp, rwake, req;
   logic oe, dp_o, dn_o, busy, done, aborted;

   int n_assert = 0;
   int n_fail   = 0;

   int cyc, first_oe, first_done, oe_cnt, done_cnt, ab_cnt, busy_cnt, kbad;
   logic [1:0] exp_k;

   always #5 clk = ~clk;

   usbdev_aon_resume_tx #(
      .IdleMinCycles (8),
      .ResumeCycles  (16),
      .CntW          (5)
   ) dut (
      .clk_aon_i   (clk),
      .rst_aon_i   (rst),
      .usb_dp_i    (dp_i),
      .usb_dn_i    (dn_i),
      .pinflip_i   (pinflip),
      .suspended_i (susp),
      .rwake_en_i  (rwake),
      .wake_req_i  (req),
      .usb_oe_o    (oe),
      .usb_dp_o    (dp_o),
      .usb_dn_o    (dn_o),
      .busy_o      (busy),
      .done_o      (done),
      .aborted_o   (aborted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cyc = -1; first_oe = -1; first_done = -1;
      oe_cnt = 0; done_cnt = 0; ab_cnt = 0; busy_cnt = 0; kbad = 0;
   endtask

   // One clock; cyc 0 is the edge that samples the request.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (oe === 1'b1) begin
         oe_cnt++;
         if (first_oe < 0) first_oe = cyc;
         if ({dp_o, dn_o} !== exp_k) kbad++;
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (first_done < 0) first_done = cyc;
      end
      if (aborted === 1'b1) ab_cnt++;
      if (busy === 1'b1) busy_cnt++;
   endtask

   initial begin
      rst = 1'b1; dp_i = 1'b1; dn_i = 1'b0; pinflip = 1'b0;
      susp = 1'b1; rwake = 1'b1; req = 1'b0; exp_k = 2'b01;
      clr();
      #12;
      chk("rst_oe", oe, 0);
      chk("rst_dpdn", {dp_o, dn_o}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_abort", {done, aborted}, 0);
      @(negedge clk); rst = 1'b0;
      repeat (3) tick();

      // Basic sequence
      req = 1'b1; clr();
      tick();
      chk("busy_e0", busy, 0);
      tick();
      chk("busy_e1", busy, 1);
      repeat (28) tick();
      chk("t1_first_oe", first_oe, 9);
      chk("t1_oe_cnt", oe_cnt, 16);
      chk("t1_kval", kbad, 0);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_first_done", first_done, 25);
      chk("t1_abort", ab_cnt, 0);
      chk("t1_end_state", {busy, oe}, 0);
      req = 1'b0; tick();

      // SE0 blip restarts the idle timer
      req = 1'b1; clr();
      repeat (6) tick();
      dp_i = 1'b0; dn_i = 1'b0;
      tick();
      dp_i = 1'b1; dn_i = 1'b0;
      repeat (30) tick();
      chk("t2_first_oe", first_oe, 15);
      chk("t2_oe_cnt", oe_cnt, 16);
      chk("t2_done_cnt", done_cnt, 1);
      req = 1'b0; tick();

      // Pin flip: J=01, K driven as 10
      pinflip = 1'b1; dp_i = 1'b0; dn_i = 1'b1; exp_k = 2'b10;
      req = 1'b1; clr();
      repeat (30) tick();
      chk("t3_first_oe", first_oe, 9);
      chk("t3_oe_cnt", oe_cnt, 16);
      chk("t3_kval", kbad, 0);
      chk("t3_done_cnt", done_cnt, 1);
      req = 1'b0; tick();
      pinflip = 1'b0; dp_i = 1'b1; dn_i = 1'b0; exp_k = 2'b01;

      // Suspend drops at DRIVE_K cycle 4
      req = 1'b1; clr();
      repeat (13) tick();
      susp = 1'b0;
      repeat (10) tick();
      chk("t4_oe_cnt", oe_cnt, 5);
      chk("t4_abort_cnt", ab_cnt, 1);
      chk("t4_done_cnt", done_cnt, 0);
      chk("t4_idle", {busy, oe}, 0);
      susp = 1'b1; clr();
      repeat (5) tick();
      chk("t4_no_retrigger", busy_cnt, 0);
      req = 1'b0; tick();

      // Abort coincident with the K terminal count
      req = 1'b1; clr();
      repeat (24) tick();
      susp = 1'b0;
      repeat (6) tick();
      chk("t5_oe_cnt", oe_cnt, 16);
      chk("t5_done_cnt", done_cnt, 0);
      chk("t5_abort_cnt", ab_cnt, 1);
      susp = 1'b1; req = 1'b0; tick();

      // Request rejected without remote-wake enable
      rwake = 1'b0; req = 1'b1; clr();
      repeat (10) tick();
      chk("t6_abort_cnt", ab_cnt, 1);
      chk("t6_busy_cnt", busy_cnt, 0);
      chk("t6_oe_cnt", oe_cnt, 0);
      rwake = 1'b1; req = 1'b0; tick();

      // Async reset during DRIVE_K cycle 10
      req = 1'b1; clr();
      repeat (19) tick();
      chk("t7_oe_before_rst", oe, 1);
      #2 rst = 1'b1;
      #1;
      chk("t7_oe_async", oe, 0);
      chk("t7_busy_async", busy, 0);
      @(negedge clk); rst = 1'b0;
      clr();
      repeat (10) tick();
      chk("t7_held_req", busy_cnt, 0);
      req = 1'b0; tick();
      req = 1'b1; clr();
      tick(); tick();
      chk("t7_retrigger", busy, 1);
      repeat (30) tick();
      chk("t7_done_cnt", done_cnt, 1);
      chk("t7_oe_cnt", oe_cnt, 16);
      req = 1'b0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/usbdev_aon_resume_tx.md
Name: usbdev_aon_resume_tx

Overview:
- Always-on transmitter for device-initiated remote wakeup. It is the counterpart of the AON wake detector, which only observes host-driven resume and reset.
- While the link is suspended and firmware has armed remote wake, it waits for the bus to stay idle (J) for the minimum time. It then drives K (resume signalling) on D+/D- for a fixed duration and releases the bus.
- It sits in the AON domain beside the wake detector. Its drive outputs are muxed onto the pad ahead of the main IP.

Parameters:
- IdleMinCycles, 1000, AON cycles of continuous J required before driving K (5 ms at 200 kHz).
- ResumeCycles, 2000, AON cycles K is driven (10 ms at 200 kHz; must be within 1-15 ms).
- CntW, 11, counter width; must satisfy 2**CntW > max(IdleMinCycles, ResumeCycles).

Ports:
- clk_aon_i  in  1  AON clock.
- rst_aon_i  in  1  asynchronous, active-high reset.
- usb_dp_i  in  1  D+ pad value (already synchronized to AON).
- usb_dn_i  in  1  D- pad value (already synchronized to AON).
- pinflip_i  in  1  D+/D- swap; J = {dp,dn}=2'b10, or 2'b01 when set.
- suspended_i  in  1  wake-detect-active status from the AON wake detector.
- rwake_en_i  in  1  host has enabled remote wake (AON-synced register).
- wake_req_i  in  1  level request from firmware to start remote wake.
- usb_oe_o  out  1  pad output enable.
- usb_dp_o  out  1  D+ drive value.
- usb_dn_o  out  1  D- drive value.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle pulse when K drive completes normally.
- aborted_o  out  1  one-cycle pulse when a request is aborted or rejected.

Behaviour:
- Reset values: state=IDLE, counter=0, usb_oe_o=0, usb_dp_o=0, usb_dn_o=0, busy_o=0, done_o=0, aborted_o=0.
- line_j = ({dp,dn} == (pinflip_i ? 2'b01 : 2'b10)).
- K drive value = inverse of J: {dp,dn} = pinflip_i ? 2'b10 : 2'b01.
- All outputs are registered, so every state effect appears one cycle after the transition edge.
- abort_cond = !suspended_i | !rwake_en_i.
- IDLE:
  - On wake_req_i & !abort_cond: go to WAIT_IDLE, cnt=0.
  - On wake_req_i & abort_cond: pulse aborted_o, stay in IDLE.
  - Request is a level; after completion, re-entry needs wake_req_i to be low for at least one cycle (wake_req_i is edge-qualified internally).
- WAIT_IDLE:
  - If line_j: cnt++. If !line_j: cnt=0, since host activity restarts the idle timer.
  - When cnt == IdleMinCycles-1 and line_j: go to DRIVE_K, cnt=0.
- DRIVE_K:
  - usb_oe_o=1 with K value; cnt++ each cycle; input line state is ignored.
  - When cnt == ResumeCycles-1: go to RELEASE.
  - K is driven for exactly ResumeCycles cycles.
- RELEASE:
  - usb_oe_o=0, drive values=0.
  - Pulse done_o; next state IDLE.
  - The host continues the resume; the wake detector reports the K as bus activity.
- Abort:
  - abort_cond in WAIT_IDLE or DRIVE_K: next state IDLE, usb_oe_o=0 the next cycle, aborted_o pulses once.
  - Abort has priority over a simultaneous counter terminal.
- wake_req_i dropping mid-sequence does not cancel; only abort_cond cancels.
- Reset asserted mid-DRIVE_K: usb_oe_o falls asynchronously to 0.
- busy_o = (state != IDLE).
- Counter never wraps: it saturates/clears at the terminal compare.

Decomposition:
- usbdev_pkg additions:
  - typedef enum logic [1:0] resume_tx_state_e {RtxIdle, RtxWaitIdle, RtxDriveK, RtxRelease}.
  - Constants UsbJFs=2'b10, UsbKFs=2'b01.
- A small sub-module usbdev_aon_line_state is natural: combinational J/K/SE0 decode with pinflip. The wake detector can reuse it.
- The counter and FSM stay in this module.

Test Plan:
- Params IdleMinCycles=8, ResumeCycles=16, pinflip=0, suspended=1, rwake_en=1, line J, wake_req rises -> busy_o next cycle; usb_oe_o=1 with {dp,dn}=01 starting 9 cycles after entry, held 16 cycles; then oe=0 and done_o pulses once.
- Same setup but line goes SE0 for 1 cycle after 5 J cycles -> idle count restarts; K drive starts 8 J cycles after the line returns to J.
- pinflip=1, J=2'b01 -> drive value {dp,dn}=10 during DRIVE_K.
- suspended_i falls at DRIVE_K cycle 4 -> oe=0 the next cycle, aborted_o pulses once, done_o never pulses, state IDLE.
- wake_req with rwake_en_i=0 -> aborted_o pulses, oe stays 0, busy_o stays 0.
- rst_aon_i asserted at DRIVE_K cycle 10 -> oe=0 immediately; after release, the module is idle and a held-high wake_req_i does not retrigger until it toggles.
